// File: rtl/qe_mac_sequencer.sv
// qe_mac_sequencer: host-side driver that issues operand beats to the quadratic/product-sum MAC and returns its result.
// Latency: op accept at t drives mac_valid_in at t+1; result reaches host one cycle after mac_valid_out (or after the timeout).
// Backpressure: job_ready only in IDLE, op_ready only in ISSUE, result held until res_ready.
module qe_mac_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int MAX_LEN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic        job_mode,
  input  logic [4:0]  job_len,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  input  logic [7:0]  op_c,
  input  logic [7:0]  op_x,
  output logic [7:0]  mac_a,
  output logic [7:0]  mac_b,
  output logic [7:0]  mac_c,
  output logic [7:0]  mac_x,
  output logic        mac_mode,
  output logic        mac_valid_in,
  output logic        mac_last_input,
  input  logic        mac_valid_out,
  input  logic [15:0] mac_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_timeout,
  output logic        busy,
  output logic [7:0]  stray_cnt
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]    state;
  logic [4:0]    len_q;
  logic [4:0]    beat_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [4:0]    eff_len;
  logic          last_beat;

  // Handshake readiness and busy follow the state register directly.
  always_comb begin
    job_ready = (state == S_IDLE);
    op_ready  = (state == S_ISSUE);
    busy      = (state != S_IDLE);
  end

  // Job length as seen by the beat counter: mode 0 is a single beat, mode 1 clamps into [1, MAX_LEN].
  always_comb begin
    eff_len = 5'd1;
    if (job_mode) begin
      if (job_len == 5'd0)
        eff_len = 5'd1;
      else if (job_len > 5'(MAX_LEN))
        eff_len = 5'(MAX_LEN);
      else
        eff_len = job_len;
    end
    last_beat = (beat_cnt == (len_q - 5'd1));
  end

  // Main sequencer: job latch, operand issue, result wait with timeout, result hold.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= S_IDLE;
      len_q          <= 5'd0;
      beat_cnt       <= 5'd0;
      tmo_cnt        <= '0;
      mac_a          <= 8'd0;
      mac_b          <= 8'd0;
      mac_c          <= 8'd0;
      mac_x          <= 8'd0;
      mac_mode       <= 1'b0;
      mac_valid_in   <= 1'b0;
      mac_last_input <= 1'b0;
      res_valid      <= 1'b0;
      res_data       <= 16'd0;
      res_timeout    <= 1'b0;
    end else begin
      // Beat strobes are single-cycle pulses unless re-armed below.
      mac_valid_in   <= 1'b0;
      mac_last_input <= 1'b0;
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            mac_mode <= job_mode;
            len_q    <= eff_len;
            beat_cnt <= 5'd0;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (op_valid) begin
            mac_a        <= op_a;
            mac_x        <= op_x;
            // Product-sum only uses a/x; keep b/c quiet so the MAC sees clean zeros.
            mac_b        <= mac_mode ? 8'd0 : op_b;
            mac_c        <= mac_mode ? 8'd0 : op_c;
            mac_valid_in <= 1'b1;
            beat_cnt     <= beat_cnt + 5'd1;
            if (last_beat) begin
              mac_last_input <= 1'b1;
              tmo_cnt        <= '0;
              state          <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A real result in the final timeout cycle still takes priority.
          if (mac_valid_out) begin
            res_data    <= mac_result;
            res_valid   <= 1'b1;
            res_timeout <= 1'b0;
            state       <= S_HOLD;
          end else if (tmo_cnt == TW'(TIMEOUT - 1)) begin
            res_data    <= 16'hFFFF;
            res_valid   <= 1'b1;
            res_timeout <= 1'b1;
            state       <= S_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: begin
          if (res_ready) begin
            res_valid   <= 1'b0;
            res_timeout <= 1'b0;
            state       <= S_IDLE;
          end
        end
      endcase
    end
  end

  // Count MAC results that arrive when nobody is waiting for one; saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (!reset)
      stray_cnt <= 8'd0;
    else if (mac_valid_out && (state != S_WAIT) && (stray_cnt != 8'hFF))
      stray_cnt <= stray_cnt + 8'd1;
  end

endmodule

// File: doc/qe_mac_sequencer.md
Name: qe_mac_sequencer

Overview:
- Initiator-side driver for the quadratic-equation / product-sum MAC interface.
- Accepts job descriptors and operand beats from a host over valid/ready handshakes.
- Drives the MAC's operand, mode, valid_in and last_input lines, waits for valid_out, then returns the 16-bit result, or a timeout indication, to the host.
- Sits between the host/control logic and the MAC.

Parameters:
- TIMEOUT, 64, cycles in WAIT without mac_valid_out before the job is aborted (must be ≥2).
- MAX_LEN, 16, maximum mode-1 operand pairs per job; job_len is 5 bits.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- job_valid  in  1  job descriptor valid
- job_ready  out  1  sequencer can accept a job
- job_mode  in  1  0 = quadratic a*x^2+b*x+c, 1 = product-sum Σa_i*x_i
- job_len  in  5  mode-1 pair count; ignored in mode 0
- op_valid  in  1  operand beat valid
- op_ready  out  1  sequencer accepts operand beat
- op_a, op_b, op_c, op_x  in  8 each  operand beat
- mac_a, mac_b, mac_c, mac_x  out  8 each  operands to MAC
- mac_mode  out  1  mode to MAC
- mac_valid_in  out  1  operand beat valid to MAC
- mac_last_input  out  1  final beat of job
- mac_valid_out  in  1  MAC result valid
- mac_result  in  16  MAC result
- res_valid  out  1  result valid to host
- res_ready  in  1  host accepts result
- res_data  out  16  result
- res_timeout  out  1  res_data is a timeout marker
- busy  out  1  state != IDLE
- stray_cnt  out  8  saturating count of mac_valid_out pulses outside WAIT

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE.
  - All outputs become 0, except job_ready=1.
  - Beat and timeout counters clear; stray_cnt clears.
  - A reset mid-job abandons the job with no further MAC traffic.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - job_ready=1.
  - A job_valid&&job_ready handshake at cycle t latches the mode and the effective length, then moves to ISSUE; op_ready=1 from t+1.
  - Effective length: 1 for mode 0; job_len for mode 1.
  - job_len=0 is treated as 1. job_len>MAX_LEN is clamped to MAX_LEN.
  - mac_mode updates on job accept and holds until the next job accept.
- ISSUE:
  - op_ready=1.
  - Each op_valid&&op_ready handshake at cycle t registers the operands onto mac_* and pulses mac_valid_in=1 for exactly cycle t+1.
  - Mode 1 drives mac_b=mac_c=0.
  - The beat counter increments per handshake.
  - The handshake carrying the final beat also asserts mac_last_input=1 in the same t+1 cycle, and the state moves to WAIT.
  - op_valid=0 inserts a gap: mac_valid_in=0; mac_a/b/c/x hold their last values.
- WAIT:
  - op_ready=0; the timeout counter starts at 0 and increments each cycle.
  - mac_valid_out=1 latches mac_result into res_data, with res_valid=1 and res_timeout=0 from the next cycle; state moves to HOLD.
  - If the counter reaches TIMEOUT-1 without mac_valid_out: res_data=16'hFFFF, res_timeout=1, res_valid=1; state moves to HOLD.
  - If mac_valid_out arrives in the same cycle the counter reaches TIMEOUT-1, mac_valid_out wins.
- HOLD:
  - res_valid, res_data and res_timeout hold stable until res_ready=1.
  - On handshake: res_valid=0, res_timeout=0, and the state returns to IDLE, with job_ready=1 the next cycle. res_data keeps its last value.
- Stray results: mac_valid_out in IDLE, ISSUE or HOLD is ignored for data and increments stray_cnt, which saturates at 255.
- Minimum round trip for a mode-0 job, with the host always valid/ready and the MAC responding with latency L:
  - job accept at t0;
  - op accept at t0+1;
  - mac_valid_in at t0+2;
  - res_valid at t0+3+L.

Test Plan:
- Mode 0, a=2, b=3, c=4, x=5; MAC model returns 69 two cycles after last_input. Required: one mac_valid_in pulse with mac_last_input=1, mac_mode=0; res_data=69, res_timeout=0.
- Mode 1, job_len=3, pairs (1,2), (3,4), (5,6), with a 2-cycle op_valid gap after the first pair; MAC model returns 44. Required: exactly 3 mac_valid_in pulses, mac_last_input only on the third, mac_b=mac_c=0; res_data=44.
- Mode 0 job with the MAC silent; TIMEOUT=64. Required: res_valid at exactly TIMEOUT cycles after WAIT entry, res_data=16'hFFFF, res_timeout=1.
- res_ready held low for 10 cycles after res_valid. Required: res_data stable, job_ready=0 throughout; job_ready=1 on the cycle after the handshake.
- reset=0 while in ISSUE after 1 of 4 beats. Required: next cycle busy=0, mac_valid_in=0, job_ready=1; a subsequent job_len=0, mode-1 job issues a single beat with mac_last_input=1.
- Three mac_valid_out pulses injected in IDLE. Required: stray_cnt=3, res_valid stays 0.
